dma_ahb_master: RTL

AHB-Lite master engine that answers the DMA arbiter's grant. While the arbiter holds a stream selected and asserts master enable, this block takes that stream's transfer configuration, issues one AHB-Lite transaction (SINGLE or INCR4/8/16), moves data between the bus and the stream FIFO, and returns master-ready so the arbiter can swap streams. It sits between the arbiter/stream mux and the AHB-Lite port.

---
 rtl/dma_pkg.sv | 72 +++++++
 rtl/dma_ahb_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: transfer size/burst encodings, AHB-Lite codes,
// master FSM states and small decode helpers used by the arbiter and master.
package dma_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE  = 2'd0,
      SIZE_HWORD = 2'd1,
      SIZE_WORD  = 2'd2,
      SIZE_WORD3 = 2'd3
   } dma_size_e;

   typedef enum logic [1:0] {
      BURST_SINGLE = 2'd0,
      BURST_INC4   = 2'd1,
      BURST_INC8   = 2'd2,
      BURST_INC16  = 2'd3
   } dma_burst_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_ERR  = 2'd3
   } dma_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // Stream-select width; never below one bit so single-stream builds stay legal.
   function automatic int dma_log2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [4:0] beats_of(input logic [1:0] burst);
      case (burst)
         BURST_INC4:  return 5'd4;
         BURST_INC8:  return 5'd8;
         BURST_INC16: return 5'd16;
         default:     return 5'd1;
      endcase
   endfunction

   function automatic logic [2:0] hburst_of(input logic [1:0] burst);
      case (burst)
         BURST_SINGLE: return HBURST_SINGLE;
         BURST_INC4:   return HBURST_INCR4;
         BURST_INC8:   return HBURST_INCR8;
         default:      return HBURST_INCR16;
      endcase
   endfunction

   // Size code 3 is not a legal beat size here and is folded onto word.
   function automatic logic [1:0] size_norm(input logic [1:0] size);
      if (size == SIZE_WORD3) return 2'(SIZE_WORD);
      return size;
   endfunction

   function automatic logic [31:0] incr_of(input logic [1:0] size);
      case (size)
         SIZE_BYTE:  return 32'd1;
         SIZE_HWORD: return 32'd2;
         default:    return 32'd4;
      endcase
   endfunction

endpackage

// File: rtl/dma_ahb_master.sv
// AHB-Lite master engine: runs one SINGLE/INCRn transaction for the stream the
// arbiter granted, moving beats between the bus and that stream's FIFO.
module dma_ahb_master
   import dma_pkg::*;
#(
   parameter int numb_ch = 4
) (
   input  logic                         i_clk,
   input  logic                         i_nreset,
   input  logic                         i_master_en,
   input  logic [dma_log2(numb_ch)-1:0] i_stream_sel,
   input  logic [31:0]                  i_addr,
   input  logic [1:0]                   i_size,
   input  logic [1:0]                   i_burst,
   input  logic                         i_write,
   input  logic [31:0]                  i_wdata,
   output logic                         o_wdata_pop,
   output logic [31:0]                  o_rdata,
   output logic                         o_rdata_push,
   output logic [dma_log2(numb_ch)-1:0] o_stream_id,
   output logic                         o_master_ready,
   output logic                         o_done,
   output logic                         o_error,
   output logic [31:0]                  o_haddr,
   output logic [1:0]                   o_htrans,
   output logic                         o_hwrite,
   output logic [2:0]                   o_hsize,
   output logic [2:0]                   o_hburst,
   output logic [31:0]                  o_hwdata,
   input  logic                         i_hready,
   input  logic                         i_hresp,
   input  logic [31:0]                  i_hrdata,
   output dma_state_e                   o_dbg_state
);

   localparam int SW = dma_log2(numb_ch);

   dma_state_e        r_state;
   dma_state_e        w_next_state;
   logic [31:0]       r_haddr;
   logic [1:0]        r_size;
   logic [2:0]        r_hburst;
   logic              r_write;
   logic [SW-1:0]     r_stream;
   logic [4:0]        r_beats_total;
   logic [4:0]        r_beats_issued;
   logic              r_pending;
   logic [31:0]       r_hwdata;
   logic [31:0]       r_rdata;
   logic              r_rdata_push;
   logic              r_done;
   logic              r_error;

   logic              w_accept;
   logic              w_bus_busy;
   logic              w_err_first;
   logic              w_addr_accept;
   logic              w_data_ok;
   logic              w_last_addr;
   logic [1:0]        w_htrans;

   // Handshake: a transaction is accepted on a rising edge where i_master_en and
   // o_master_ready are both high; i_master_en is not looked at again until
   // o_master_ready returns, so a dropped grant cannot cut a burst short.
   assign w_accept      = (r_state == ST_IDLE) && i_master_en;
   assign w_bus_busy    = (r_state == ST_ADDR) || (r_state == ST_DATA);
   assign w_err_first   = w_bus_busy && r_pending && i_hresp && !i_hready;
   assign w_addr_accept = (r_state == ST_ADDR) && i_hready && !(r_pending && i_hresp);
   assign w_data_ok     = w_bus_busy && r_pending && i_hready && !i_hresp;
   assign w_last_addr   = (r_beats_issued == (r_beats_total - 5'd1));

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // The first error cycle drops HTRANS to IDLE combinationally so the beat
   // queued behind the failing one is never presented to the slave.
   always_comb begin
      w_next_state = r_state;
      w_htrans     = HTRANS_IDLE;
      case (r_state)
         ST_IDLE: begin
            if (i_master_en) w_next_state = ST_ADDR;
         end
         ST_ADDR: begin
            if (w_err_first) begin
               w_next_state = ST_ERR;
            end else begin
               w_htrans = (r_beats_issued == 5'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
               if (w_addr_accept && w_last_addr) w_next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_err_first)    w_next_state = ST_ERR;
            else if (w_data_ok) w_next_state = ST_IDLE;
         end
         ST_ERR: begin
            if (i_hready) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_haddr        <= 32'd0;
         r_size         <= 2'd0;
         r_hburst       <= 3'd0;
         r_write        <= 1'b0;
         r_stream       <= '0;
         r_beats_total  <= 5'd0;
         r_beats_issued <= 5'd0;
         r_pending      <= 1'b0;
         r_hwdata       <= 32'd0;
         r_rdata        <= 32'd0;
         r_rdata_push   <= 1'b0;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
      end else begin
         r_rdata_push <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;

         if (w_accept) begin
            r_haddr        <= i_addr;
            r_size         <= size_norm(i_size);
            r_hburst       <= hburst_of(i_burst);
            r_write        <= i_write;
            r_stream       <= i_stream_sel;
            r_beats_total  <= beats_of(i_burst);
            r_beats_issued <= 5'd0;
            r_pending      <= 1'b0;
         end

         if (w_addr_accept) begin
            r_haddr        <= r_haddr + incr_of(r_size);
            r_beats_issued <= r_beats_issued + 5'd1;
            if (r_write) r_hwdata <= i_wdata;
         end

         // A data phase is outstanding exactly when the last completed bus
         // cycle accepted an address; wait states freeze it.
         if (w_bus_busy) begin
            if (w_err_first)   r_pending <= 1'b0;
            else if (i_hready) r_pending <= w_addr_accept;
         end

         if (w_data_ok && !r_write) begin
            r_rdata      <= i_hrdata;
            r_rdata_push <= 1'b1;
         end

         if ((r_state == ST_DATA) && w_data_ok) r_done  <= 1'b1;
         if ((r_state == ST_ERR) && i_hready)   r_error <= 1'b1;
      end
   end

   assign o_wdata_pop    = w_addr_accept && r_write;
   assign o_rdata        = r_rdata;
   assign o_rdata_push   = r_rdata_push;
   assign o_stream_id    = r_stream;
   assign o_master_ready = (r_state == ST_IDLE);
   assign o_done         = r_done;
   assign o_error        = r_error;
   assign o_haddr        = r_haddr;
   assign o_htrans       = w_htrans;
   assign o_hwrite       = r_write;
   assign o_hsize        = {1'b0, r_size};
   assign o_hburst       = r_hburst;
   assign o_hwdata       = r_hwdata;
   assign o_dbg_state    = r_state;

endmodule
